// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM array: channel mode encoding.
// Optional feature macro: LED_PWM_BREATHE_EN (enables breathe mode in led_channel).
package led_pkg;

    // Channel mode. BREATHE falls back to OFF behaviour when breathe support is not built.
    typedef enum logic [1:0] {
        LED_MODE_OFF     = 2'd0,
        LED_MODE_ON      = 2'd1,
        LED_MODE_WINDOW  = 2'd2,
        LED_MODE_BREATHE = 2'd3
    } led_mode_t;

endpackage

// File: rtl/led_pwm_array_channel.sv
// One LED channel: shadow/active settings, optional breathe duty state,
// compare against the shared period counter and registered LED output.
// Optional feature macro: LED_PWM_BREATHE_EN. When undefined, mode 3 acts as
// OFF and no duty/direction registers exist.
module led_channel
    import led_pkg::*;
#(
    parameter int CNT_W   = 21
`ifdef LED_PWM_BREATHE_EN
    ,
    parameter int BR_STEP = 20_000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_mode,
    input  logic [CNT_W-1:0] wr_start,
    input  logic [CNT_W-1:0] wr_end,
    input  logic             wrap,
    input  logic [CNT_W-1:0] count,
    output logic             led
);

    led_mode_t        sh_mode;
    logic [CNT_W-1:0] sh_start;
    logic [CNT_W-1:0] sh_end;
    led_mode_t        act_mode;
    logic [CNT_W-1:0] act_start;
    logic [CNT_W-1:0] act_end;
    logic             led_next;

    // Shadow set: captures the most recent write; last write before wrap wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_mode  <= LED_MODE_OFF;
            sh_start <= '0;
            sh_end   <= '0;
        end else if (wr_en) begin
            sh_mode  <= led_mode_t'(wr_mode);
            sh_start <= wr_start;
            sh_end   <= wr_end;
        end
    end

    // Active set: copies the pre-edge shadow only at period wrap, so outputs never glitch mid-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_mode  <= LED_MODE_OFF;
            act_start <= '0;
            act_end   <= '0;
        end else if (wrap) begin
            act_mode  <= sh_mode;
            act_start <= sh_start;
            act_end   <= sh_end;
        end
    end

`ifdef LED_PWM_BREATHE_EN
    logic [CNT_W-1:0] duty;
    logic             dir_down;
    logic [CNT_W:0]   step_w;
    logic [CNT_W:0]   sum_up;
    logic [CNT_W-1:0] up_res;
    logic [CNT_W-1:0] down_res;

    // Next duty candidates, computed one bit wider so duty + step cannot overflow.
    always_comb begin
        step_w   = (CNT_W + 1)'(BR_STEP);
        sum_up   = {1'b0, duty} + step_w;
        up_res   = (sum_up >= {1'b0, act_end}) ? act_end : sum_up[CNT_W-1:0];
        down_res = ({1'b0, duty} <= step_w) ? '0 : (duty - step_w[CNT_W-1:0]);
    end

    // Duty ramp: steps once per period while breathing; any other mode parks it at 0, counting up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty     <= '0;
            dir_down <= 1'b0;
        end else if (act_mode != LED_MODE_BREATHE) begin
            duty     <= '0;
            dir_down <= 1'b0;
        end else if (wrap) begin
            if (!dir_down) begin
                duty <= up_res;
                if (up_res == act_end) begin
                    dir_down <= 1'b1;
                end
            end else begin
                duty <= down_res;
                if (down_res == '0) begin
                    dir_down <= 1'b0;
                end
            end
        end
    end
`endif

    // Output decision for the current count; windows never wrap, so start >= end yields 0.
    always_comb begin
        led_next = 1'b0;
        case (act_mode)
            LED_MODE_OFF:    led_next = 1'b0;
            LED_MODE_ON:     led_next = 1'b1;
            LED_MODE_WINDOW: led_next = (count >= act_start) && (count < act_end);
`ifdef LED_PWM_BREATHE_EN
            LED_MODE_BREATHE: led_next = (count < duty);
`else
            LED_MODE_BREATHE: led_next = 1'b0;
`endif
            default:         led_next = 1'b0;
        endcase
    end

    // Registered LED drive: one cycle behind the counter value it was compared against.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= 1'b0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: rtl/led_pwm_array.sv
// Multi-channel LED PWM generator: shared free-running period counter, wrap
// detect, Period_Tick and write decode feeding N_CH led_channel instances.
// Optional feature macro: LED_PWM_BREATHE_EN (breathe mode on channel mode 3).
// Write port: Wr_En is a single-cycle strobe with no backpressure; every
// strobe with Wr_Ch < N_CH is accepted, other channel indices are dropped.
module led_pwm_array
    import led_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 21,
    parameter int PERIOD  = 2_000_000,
    parameter int BR_STEP = 20_000,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Wr_En,
    input  logic [CH_W-1:0]  Wr_Ch,
    input  logic [1:0]       Wr_Mode,
    input  logic [CNT_W-1:0] Wr_Start,
    input  logic [CNT_W-1:0] Wr_End,
    output logic [N_CH-1:0]  LED_Out,
    output logic             Period_Tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;
    logic             wrap;
    logic [N_CH-1:0]  wr_sel;

    assign wrap = (count == LAST);

    // Period counter 0..PERIOD-1; the tick is registered so it lines up with count == 0.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count       <= '0;
            Period_Tick <= 1'b0;
        end else begin
            count       <= wrap ? '0 : (count + CNT_W'(1));
            Period_Tick <= wrap;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        // Channel select; indices at or above N_CH never match any channel.
        assign wr_sel[c] = Wr_En && (Wr_Ch == CH_W'(c));

        led_channel #(
            .CNT_W   (CNT_W)
`ifdef LED_PWM_BREATHE_EN
            ,
            .BR_STEP (BR_STEP)
`endif
        ) u_ch (
            .clk      (CLK),
            .rst_n    (RSTn),
            .wr_en    (wr_sel[c]),
            .wr_mode  (Wr_Mode),
            .wr_start (Wr_Start),
            .wr_end   (Wr_End),
            .wrap     (wrap),
            .count    (count),
            .led      (LED_Out[c])
        );
    end

endmodule

// File: tb/tb_led_pwm_array.sv
// Directed bench for led_pwm_array with PERIOD = 20, CNT_W = 5, BR_STEP = 4.
// CH_W is widened to 3 so that an out-of-range channel index (7) can be driven.
module tb_led_pwm_array;
    import led_pkg::*;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 5;
    localparam int PERIOD  = 20;
    localparam int BR_STEP = 4;
    localparam int CH_W    = 3;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic             Wr_En = 1'b0;
    logic [CH_W-1:0]  Wr_Ch = '0;
    logic [1:0]       Wr_Mode = '0;
    logic [CNT_W-1:0] Wr_Start = '0;
    logic [CNT_W-1:0] Wr_End = '0;
    logic [N_CH-1:0]  LED_Out;
    logic             Period_Tick;

    int total = 0;
    int bad   = 0;

    logic [N_CH-1:0] cap      [PERIOD];
    logic            tick_cap [PERIOD];

    led_pwm_array #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .PERIOD  (PERIOD),
        .BR_STEP (BR_STEP),
        .CH_W    (CH_W)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Wr_En       (Wr_En),
        .Wr_Ch       (Wr_Ch),
        .Wr_Mode     (Wr_Mode),
        .Wr_Start    (Wr_Start),
        .Wr_End      (Wr_End),
        .LED_Out     (LED_Out),
        .Period_Tick (Period_Tick)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Driver: one write strobe, issued at a falling edge and captured by the next rising edge.
    task automatic do_write(input int ch, input int mode, input int start, input int fin);
        Wr_En    = 1'b1;
        Wr_Ch    = CH_W'(ch);
        Wr_Mode  = 2'(mode);
        Wr_Start = CNT_W'(start);
        Wr_End   = CNT_W'(fin);
        @(negedge CLK);
        Wr_En    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Advance to the next falling edge where Period_Tick is high (count == 0), bounded.
    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !found; i++) begin
            @(negedge CLK);
            if (Period_Tick) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_tick: got no Period_Tick, required one within %0d cycles", 3 * PERIOD);
        end
    endtask

    // Record one period; cap[i] is the LED state that reflects count == i.
    task automatic capture();
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge CLK);
            cap[i]      = LED_Out;
            tick_cap[i] = Period_Tick;
        end
    endtask

    task automatic test_reset();
        int n;
        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if (LED_Out !== 4'b0000) begin
            bad++;
            $display("FAIL reset_led: got %b required %b", LED_Out, 4'b0000);
        end
        total++;
        if (Period_Tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_tick: got %b required 0", Period_Tick);
        end
        RSTn = 1'b1;
        n = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge CLK);
            n++;
            if (Period_Tick === 1'b1) break;
        end
        total++;
        if (n !== PERIOD) begin
            bad++;
            $display("FAIL first_tick: got tick after %0d cycles required %0d", n, PERIOD);
        end
        @(negedge CLK);
        total++;
        if (Period_Tick !== 1'b0) begin
            bad++;
            $display("FAIL tick_width: got %b one cycle after tick required 0", Period_Tick);
        end
    endtask

    task automatic test_window();
        logic [N_CH-1:0] exp;
        idle(3);
        do_write(0, int'(LED_MODE_WINDOW), 5, 10);
        wait_tick();
        capture();
        for (int i = 0; i < PERIOD; i++) begin
            exp = (i >= 5 && i < 10) ? 4'b0001 : 4'b0000;
            total++;
            if (cap[i] !== exp) begin
                bad++;
                $display("FAIL window count=%0d: got %b required %b", i, cap[i], exp);
            end
            total++;
            if (tick_cap[i] !== (i == PERIOD - 1)) begin
                bad++;
                $display("FAIL window_tick count=%0d: got %b required %b", i, tick_cap[i], (i == PERIOD - 1));
            end
        end
    endtask

    task automatic test_shadow();
        logic [N_CH-1:0] exp;
        // Write ch1 ON while count == PERIOD-1 (the wrap cycle).
        idle(PERIOD - 1);
        do_write(1, int'(LED_MODE_ON), 0, 0);
        capture();
        for (int i = 0; i < PERIOD; i++) begin
            exp = (i >= 5 && i < 10) ? 4'b0001 : 4'b0000;
            total++;
            if (cap[i] !== exp) begin
                bad++;
                $display("FAIL shadow_wrap_write_p0 count=%0d: got %b required %b", i, cap[i], exp);
            end
        end
        capture();
        for (int i = 0; i < PERIOD; i++) begin
            exp = (i >= 5 && i < 10) ? 4'b0011 : 4'b0010;
            total++;
            if (cap[i] !== exp) begin
                bad++;
                $display("FAIL shadow_wrap_write_p1 count=%0d: got %b required %b", i, cap[i], exp);
            end
        end
        // Out-of-range channel index must not touch any channel.
        idle(3);
        do_write(7, int'(LED_MODE_ON), 0, 0);
        wait_tick();
        capture();
        for (int i = 0; i < PERIOD; i++) begin
            exp = (i >= 5 && i < 10) ? 4'b0011 : 4'b0010;
            total++;
            if (cap[i] !== exp) begin
                bad++;
                $display("FAIL bad_channel count=%0d: got %b required %b", i, cap[i], exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        idle(2);
        do_write(0, int'(LED_MODE_WINDOW), 8, 8);
        do_write(1, int'(LED_MODE_WINDOW), 12, 3);
        do_write(2, int'(LED_MODE_ON), 0, 0);
        do_write(3, int'(LED_MODE_ON), 0, 0);
        do_write(3, int'(LED_MODE_OFF), 0, 0);
        wait_tick();
        capture();
        for (int i = 0; i < PERIOD; i++) begin
            total++;
            if (cap[i] !== 4'b0100) begin
                bad++;
                $display("FAIL degenerate count=%0d: got %b required %b", i, cap[i], 4'b0100);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        idle(2);
        do_write(0, int'(LED_MODE_ON), 0, 0);
        wait_tick();
        idle(5);
        total++;
        if (LED_Out !== 4'b0101) begin
            bad++;
            $display("FAIL pre_reset_led: got %b required %b", LED_Out, 4'b0101);
        end
        #2;
        RSTn = 1'b0;
        #1;
        total++;
        if (LED_Out !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset_led: got %b required %b", LED_Out, 4'b0000);
        end
        total++;
        if (Period_Tick !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_tick: got %b required 0", Period_Tick);
        end
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        n = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge CLK);
            n++;
            if (Period_Tick === 1'b1) break;
        end
        total++;
        if (n !== PERIOD) begin
            bad++;
            $display("FAIL post_reset_tick: got tick after %0d cycles required %0d", n, PERIOD);
        end
        capture();
        for (int i = 0; i < PERIOD; i++) begin
            total++;
            if (cap[i] !== 4'b0000) begin
                bad++;
                $display("FAIL post_reset_off count=%0d: got %b required %b", i, cap[i], 4'b0000);
            end
        end
    endtask

    task automatic test_breathe();
        int duties [8] = '{0, 4, 8, 12, 8, 4, 0, 4};
        logic [N_CH-1:0] exp;
        idle(3);
        do_write(2, int'(LED_MODE_BREATHE), 3, 12);
        wait_tick();
        for (int p = 0; p < 8; p++) begin
            capture();
            for (int i = 0; i < PERIOD; i++) begin
`ifdef LED_PWM_BREATHE_EN
                exp = (i < duties[p]) ? 4'b0100 : 4'b0000;
`else
                exp = 4'b0000;
`endif
                total++;
                if (cap[i] !== exp) begin
                    bad++;
                    $display("FAIL breathe period=%0d count=%0d: got %b required %b (duty %0d)",
                             p, i, cap[i], exp, duties[p]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_shadow();
        test_back_to_back();
        test_async_reset();
        test_breathe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
